// File: rtl/serial_slave_port_pkg.sv
// Shared definitions for the serial slave port: FSM states, transfer modes
// and a small width helper.
package serial_slave_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    MEM_WRITE,
    MEM_READ,
    SPLIT_WAIT,
    RDATA_SEND
  } state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_slave_port_if.sv
// Bit-serial system bus between a master-side port and a slave-side port.
interface serial_slave_port_if;

  logic swdata;
  logic smode;
  logic mvalid;
  logic srdata;
  logic svalid;
  logic sready;
  logic ssplit;
  logic split_grant;

  modport master (
    output swdata, smode, mvalid, split_grant,
    input  srdata, svalid, sready, ssplit
  );

  modport slave (
    input  swdata, smode, mvalid, split_grant,
    output srdata, svalid, sready, ssplit
  );

endinterface

// File: rtl/serial_shift_rx.sv
// Serial-to-parallel shifter, LSB first. 'done' flags the cycle in which the
// final bit is being shifted in; the counter rewinds for the next word.
module serial_shift_rx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = en && (cnt == CNT_W'(WIDTH - 1));

  // Shift a bit in from the top on each enabled cycle and count it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      data <= '0;
    end else if (en) begin
      data <= (data >> 1) | (WIDTH'(din) << (WIDTH - 1));
      cnt  <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_slave_port.sv
// Responder end of the bit-serial system bus. Deserialises address/write data
// into a parallel memory request and serialises read data back to the bus.
// Optional split transactions: define SERIAL_SLAVE_PORT_SPLIT_EN.
module serial_slave_port
  import serial_slave_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SPLIT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  serial_slave_port_if.slave    bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int unsigned CNT_W  = $clog2(max_u(ADDR_WIDTH, DATA_WIDTH) + 1);
  localparam int unsigned WAIT_W = $clog2(SPLIT_LATENCY + 1);

  state_e                state_q, state_d;
  state_e                after_addr;
  logic                  mode_q, cur_mode;
  logic                  addr_en, addr_done;
  logic                  wdat_en, wdat_done;
  logic                  rd_capture;
  logic                  tx_last;
  logic [CNT_W-1:0]      tx_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  mem_ren_q;

  // Mode is taken straight from the bus on the first bit, latched afterwards.
  assign cur_mode = (state_q == IDLE) ? bus.smode : mode_q;
  assign addr_en  = bus.mvalid && ((state_q == IDLE) || (state_q == ADDR));
  assign wdat_en  = bus.mvalid && (state_q == WDATA);
  assign tx_last  = (tx_cnt == CNT_W'(DATA_WIDTH - 1));
  assign mem_ren  = mem_ren_q;

  // The shift registers double as mem_addr/mem_wdata: each holds its last
  // word until the next transaction starts shifting into it.
  serial_shift_rx #(.WIDTH(ADDR_WIDTH), .CNT_W(CNT_W)) u_addr_rx (
    .clk  (clk),
    .rstn (rstn),
    .en   (addr_en),
    .din  (bus.swdata),
    .data (mem_addr),
    .done (addr_done)
  );

  serial_shift_rx #(.WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_wdat_rx (
    .clk  (clk),
    .rstn (rstn),
    .en   (wdat_en),
    .din  (bus.swdata),
    .data (mem_wdata),
    .done (wdat_done)
  );

`ifdef SERIAL_SLAVE_PORT_SPLIT_EN
  logic held_q, grant_q;

  assign rd_capture = mem_rvalid &&
                      ((state_q == MEM_READ) || ((state_q == SPLIT_WAIT) && !held_q));

  // Remember read data and grant independently while the bus is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      held_q  <= 1'b0;
      grant_q <= 1'b0;
    end else if (state_q != SPLIT_WAIT) begin
      held_q  <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      if (mem_rvalid)      held_q  <= 1'b1;
      if (bus.split_grant) grant_q <= 1'b1;
    end
  end
`else
  logic unused_split_grant;

  assign unused_split_grant = bus.split_grant;
  assign rd_capture         = mem_rvalid && (state_q == MEM_READ);
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and bus-side outputs.
  always_comb begin
    state_d    = state_q;
    after_addr = (cur_mode == MODE_WRITE) ? WDATA : MEM_READ;
    bus.sready = 1'b0;
    bus.svalid = 1'b0;
    bus.ssplit = 1'b0;
    mem_wen    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.sready = 1'b1;
        if (bus.mvalid) state_d = addr_done ? after_addr : ADDR;
      end
      ADDR: begin
        if (addr_done) state_d = after_addr;
      end
      WDATA: begin
        if (wdat_done) state_d = MEM_WRITE;
      end
      MEM_WRITE: begin
        mem_wen = 1'b1;
        state_d = IDLE;
      end
      MEM_READ: begin
        if (mem_rvalid) state_d = RDATA_SEND;
`ifdef SERIAL_SLAVE_PORT_SPLIT_EN
        else if (wait_cnt == WAIT_W'(SPLIT_LATENCY)) begin
          state_d    = SPLIT_WAIT;
          bus.ssplit = 1'b1;
        end
`endif
      end
      SPLIT_WAIT: begin
`ifdef SERIAL_SLAVE_PORT_SPLIT_EN
        if ((held_q || mem_rvalid) && (grant_q || bus.split_grant)) state_d = RDATA_SEND;
`else
        state_d = IDLE;
`endif
      end
      RDATA_SEND: begin
        bus.svalid = 1'b1;
        if (tx_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bus.srdata = bus.svalid & rdata_q[0];
  end

  // Mode latch, read strobe, wait counter and read-data serialiser.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q    <= MODE_READ;
      mem_ren_q <= 1'b0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      tx_cnt    <= '0;
    end else begin
      if ((state_q == IDLE) && bus.mvalid) mode_q <= bus.smode;
      mem_ren_q <= addr_done && (cur_mode == MODE_READ);
      if (state_q != MEM_READ)
        wait_cnt <= '0;
      else if (!mem_rvalid && (wait_cnt != WAIT_W'(SPLIT_LATENCY)))
        wait_cnt <= wait_cnt + 1'b1;
      if (rd_capture)
        rdata_q <= mem_rdata;
      else if (state_q == RDATA_SEND)
        rdata_q <= rdata_q >> 1;
      if (state_q == RDATA_SEND) tx_cnt <= tx_last ? '0 : tx_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port: writes, stalled writes, reads,
// reset abort, and split reads when SERIAL_SLAVE_PORT_SPLIT_EN is defined.
module tb_serial_slave_port;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;

  int cyc       = 0;
  int wen_count = 0;
  int n_checks  = 0;
  int n_pass    = 0;

  serial_slave_port_if bus_if ();

  serial_slave_port #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .SPLIT_LATENCY (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus_if),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (mem_wen === 1'b1) wen_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive n bits LSB first, inserting stall_len idle cycles before bit stall_pos.
  task automatic send_bits(input logic [31:0] val, input int n, input int stall_pos,
                           input int stall_len);
    for (int i = 0; i < n; i++) begin
      if (i == stall_pos)
        for (int s = 0; s < stall_len; s++) begin
          bus_if.mvalid = 1'b0;
          next_cycle();
        end
      bus_if.mvalid = 1'b1;
      bus_if.swdata = val[i];
      if (i == 1) begin
        #2;
        check("sready_drop", {31'd0, bus_if.sready}, 32'd0);
      end
      next_cycle();
    end
    bus_if.mvalid = 1'b0;
    bus_if.swdata = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int stall_pos, input int stall_len, input int exp_lat);
    int start;
    int lat;
    int wen0;
    lat = -1;
    #2;
    check({tag, "_sready_idle"}, {31'd0, bus_if.sready}, 32'd1);
    wen0         = wen_count;
    start        = cyc;
    bus_if.smode = 1'b1;
    send_bits(32'(addr), AW, stall_pos, stall_len);
    send_bits(32'(data), DW, -1, 0);
    for (int i = 0; i < 10; i++) begin
      #2;
      if (mem_wen === 1'b1) begin
        lat = cyc - start;
        check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        check({tag, "_wdata"}, 32'(mem_wdata), 32'(data));
        break;
      end
      next_cycle();
    end
    check({tag, "_latency"}, lat, exp_lat);
    next_cycle();
    #2;
    check({tag, "_wen_pulse"}, {31'd0, mem_wen}, 32'd0);
    check({tag, "_sready_back"}, {31'd0, bus_if.sready}, 32'd1);
    check({tag, "_wen_count"}, wen_count - wen0, 32'd1);
    next_cycle();
  endtask

  // Cycle c counts from the first MEM_READ cycle (the mem_ren cycle) as 0.
  task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] rd,
                         input int rv_at, input int gr_at, input int exp_split_at,
                         input int exp_start);
    int            c_split;
    int            n_split;
    int            start;
    int            nsv;
    logic [DW-1:0] got;
    logic          broke;
    c_split = -1;
    n_split = 0;
    start   = -1;
    nsv     = 0;
    got     = '0;
    broke   = 1'b0;
    bus_if.smode = 1'b0;
    send_bits(32'(addr), AW, -1, 0);
    for (int c = 0; c < 60; c++) begin
      mem_rvalid         = (c == rv_at);
      mem_rdata          = (c == rv_at) ? rd : '0;
      bus_if.split_grant = (c == gr_at);
      #2;
      if (c == 0) begin
        check({tag, "_ren"}, {31'd0, mem_ren}, 32'd1);
        check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
      end
      if (c == 1) check({tag, "_ren_pulse"}, {31'd0, mem_ren}, 32'd0);
      if (bus_if.ssplit === 1'b1) begin
        n_split++;
        if (c_split < 0) c_split = c;
      end
      if (bus_if.svalid === 1'b1) begin
        if (start < 0) start = c;
        if (nsv < DW) got[nsv] = bus_if.srdata;
        nsv++;
      end else if (start >= 0) begin
        check({tag, "_sready_after"}, {31'd0, bus_if.sready}, 32'd1);
        broke = 1'b1;
        break;
      end
      next_cycle();
    end
    mem_rvalid         = 1'b0;
    mem_rdata          = '0;
    bus_if.split_grant = 1'b0;
    check({tag, "_split_count"}, n_split, (exp_split_at < 0) ? 32'd0 : 32'd1);
    check({tag, "_split_cycle"}, c_split, exp_split_at);
    check({tag, "_send_start"}, start, exp_start);
    check({tag, "_svalid_len"}, nsv, DW);
    check({tag, "_rdata"}, 32'(got), 32'(rd));
    if (broke) next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    int wen0;
    rstn               = 1'b0;
    bus_if.swdata      = 1'b0;
    bus_if.smode       = 1'b0;
    bus_if.mvalid      = 1'b0;
    bus_if.split_grant = 1'b0;
    mem_rdata          = '0;
    mem_rvalid         = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_sready", {31'd0, bus_if.sready}, 32'd1);
    check("rst_svalid", {31'd0, bus_if.svalid}, 32'd0);
    check("rst_srdata", {31'd0, bus_if.srdata}, 32'd0);
    check("rst_ssplit", {31'd0, bus_if.ssplit}, 32'd0);
    check("rst_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_ren", {31'd0, mem_ren}, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    rstn = 1'b1;
    next_cycle();

    // 12 address + 8 data bits, strobe one cycle after the last bit.
    do_write("wr_basic", 12'h0A5, 8'h3C, -1, 0, 20);
    do_write("wr_stall", 12'h0A5, 8'h3C, 6, 3, 23);

    do_read("rd_fff", 12'hFFF, 8'hA7, 2, -1, -1, 3);
`ifdef SERIAL_SLAVE_PORT_SPLIT_EN
    do_read("rd_split", 12'h000, 8'h5A, 10, 15, 4, 16);
    do_read("rd_at4", 12'h3C3, 8'h96, 4, -1, -1, 5);
    do_read("rd_grant_first", 12'h801, 8'h69, 9, 6, 4, 10);
`else
    do_read("rd_long", 12'h000, 8'h5A, 10, 15, -1, 11);
`endif

    // Abort during data bit 3 of a write.
    wen0         = wen_count;
    bus_if.smode = 1'b1;
    send_bits(32'h7E1, AW, -1, 0);
    send_bits(32'h3C, 3, -1, 0);
    bus_if.mvalid = 1'b1;
    bus_if.swdata = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check("abort_sready", {31'd0, bus_if.sready}, 32'd1);
    check("abort_wen", {31'd0, mem_wen}, 32'd0);
    check("abort_svalid", {31'd0, bus_if.svalid}, 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_wdata", 32'(mem_wdata), 32'd0);
    bus_if.mvalid = 1'b0;
    bus_if.swdata = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b1;
    next_cycle();
    check("abort_no_wen", wen_count - wen0, 32'd0);
    do_write("wr_after_rst", 12'h123, 8'hC5, -1, 0, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
